// File: rtl/mem_responder.sv
// mem_responder: dual-port word memory with an instruction fetch port and a
// data access port, self-clearing after reset, with address protection and a
// saturating fault counter.
// Optional feature macro: LALU_MEM_PROTECT_EN (user-mode kernel-region check).
module mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [15:0] KERNEL_BASE = 16'h0200
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        operationMode,
  input  logic [15:0] fetchAddress,
  output logic [31:0] fetchOutput,
  input  logic [15:0] memAccessAddress,
  input  logic        memAccessWren,
  input  logic [31:0] memAccessData,
  input  logic        memAccessRden,
  output logic [31:0] memAccessOutput,
  output logic        ready,
  output logic        accessFault,
  output logic [7:0]  faultCount
);

  localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic {INIT, READY} stateT;

  stateT         state;
  stateT         nextState;
  logic [AW-1:0] clearPtr;
  logic [31:0]   words [DEPTH];

  logic          fetchLegal;
  logic          accessLegal;
  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [31:0]   memWdata;
  logic          writeLegal;
  logic          faultNow;

  // Legality: addresses beyond DEPTH are always rejected; with protection
  // enabled, user mode may not touch anything at or above KERNEL_BASE.
`ifdef LALU_MEM_PROTECT_EN
  assign fetchLegal  = ({1'b0, fetchAddress} < DEPTH_LIMIT) &&
                       (operationMode || (fetchAddress < KERNEL_BASE));
  assign accessLegal = ({1'b0, memAccessAddress} < DEPTH_LIMIT) &&
                       (operationMode || (memAccessAddress < KERNEL_BASE));
`else
  logic unusedConfig;
  assign fetchLegal   = ({1'b0, fetchAddress} < DEPTH_LIMIT);
  assign accessLegal  = ({1'b0, memAccessAddress} < DEPTH_LIMIT);
  assign unusedConfig = ^{operationMode, KERNEL_BASE};
`endif

  // State register: reset always restarts the clearing sweep.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= INIT;
    else          state <= nextState;
  end

  // Next state: leave INIT once the last word has been cleared.
  always_comb begin
    nextState = state;
    case (state)
      INIT:    if (clearPtr == LAST_WORD) nextState = READY;
      READY:   nextState = READY;
      default: nextState = INIT;
    endcase
  end

  // Outputs of the FSM: who owns the memory write port and whether this cycle faults.
  always_comb begin
    memWe      = 1'b0;
    memWaddr   = '0;
    memWdata   = '0;
    writeLegal = 1'b0;
    faultNow   = 1'b0;
    case (state)
      INIT: begin
        memWe    = 1'b1;
        memWaddr = clearPtr;
      end
      READY: begin
        writeLegal = memAccessWren && accessLegal;
        memWe      = writeLegal;
        memWaddr   = memAccessAddress[AW-1:0];
        memWdata   = memAccessData;
        faultNow   = !fetchLegal ||
                     ((memAccessWren || memAccessRden) && !accessLegal);
      end
      default: ;
    endcase
  end

  // Clear pointer walks the whole array while initialising.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)           clearPtr <= '0;
    else if (state == INIT) clearPtr <= clearPtr + AW'(1);
  end

  // Ready goes high on the same edge that clears the final word.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) ready <= 1'b0;
    else          ready <= (nextState == READY);
  end

  // Storage array has no reset; zeroing happens only through the INIT sweep.
  always_ff @(posedge CLOCK_50) begin
    if (memWe) words[memWaddr] <= memWdata;
  end

  // Registered read ports; fetch forwards same-cycle write data, access reads old data.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      fetchOutput     <= '0;
      memAccessOutput <= '0;
    end else if (state == INIT) begin
      fetchOutput     <= '0;
      memAccessOutput <= '0;
    end else begin
      if (!fetchLegal)
        fetchOutput <= '0;
      else if (writeLegal && (memAccessAddress == fetchAddress))
        fetchOutput <= memAccessData;
      else
        fetchOutput <= words[fetchAddress[AW-1:0]];
      if (memAccessRden)
        memAccessOutput <= accessLegal ? words[memAccessAddress[AW-1:0]] : 32'h0;
    end
  end

  // Fault pulse and saturating counter, at most one increment per cycle.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      accessFault <= 1'b0;
      faultCount  <= '0;
    end else begin
      accessFault <= faultNow;
      if (faultNow && (faultCount != 8'hFF)) faultCount <= faultCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: randomized and directed traffic checked by a
// queue-based scoreboard against a word-array reference model.
// Honours LALU_MEM_PROTECT_EN in the same way as the design.
module tb_mem_responder;

  localparam int          DEPTH       = 1024;
  localparam logic [15:0] KERNEL_BASE = 16'h0200;
`ifdef LALU_MEM_PROTECT_EN
  localparam bit PROTECT_ON = 1'b1;
`else
  localparam bit PROTECT_ON = 1'b0;
`endif

  logic        CLOCK_50;
  logic        RESET_N;
  logic        operationMode;
  logic [15:0] fetchAddress;
  logic [31:0] fetchOutput;
  logic [15:0] memAccessAddress;
  logic        memAccessWren;
  logic [31:0] memAccessData;
  logic        memAccessRden;
  logic [31:0] memAccessOutput;
  logic        ready;
  logic        accessFault;
  logic [7:0]  faultCount;

  typedef struct {
    logic [31:0] fetch;
    logic [31:0] mem;
    logic        fault;
    logic [7:0]  count;
  } expectT;

  expectT      sbq[$];
  logic [31:0] model [DEPTH];
  logic [31:0] modelMemOut;
  int          modelCount;
  int          checks;
  int          errors;

  mem_responder #(.DEPTH(DEPTH), .KERNEL_BASE(KERNEL_BASE)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .operationMode(operationMode),
    .fetchAddress(fetchAddress),
    .fetchOutput(fetchOutput),
    .memAccessAddress(memAccessAddress),
    .memAccessWren(memAccessWren),
    .memAccessData(memAccessData),
    .memAccessRden(memAccessRden),
    .memAccessOutput(memAccessOutput),
    .ready(ready),
    .accessFault(accessFault),
    .faultCount(faultCount)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One comparison, counted; mismatches print a FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // An address is usable if it names a stored word and, when protection is
  // on, user mode stays below the kernel region.
  function automatic bit legalAddr(input logic [15:0] a, input logic kernel);
    bit ok;
    ok = (int'(a) < DEPTH);
    if (PROTECT_ON && !kernel && (a >= KERNEL_BASE)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [15:0] pickAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return 16'($urandom_range(0, 15));
    else if (r == 6) return 16'($urandom_range(int'(KERNEL_BASE) - 2, int'(KERNEL_BASE) + 2));
    else if (r == 7) return 16'($urandom_range(DEPTH - 2, DEPTH + 1));
    else if (r == 8) return 16'($urandom);
    else             return 16'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    modelMemOut = 32'h0;
    modelCount  = 0;
    sbq.delete();
  endtask

  // Drive one request cycle and push what the memory should show after the edge.
  task automatic applyStimulus(input logic mode, input logic [15:0] fa,
                               input logic [15:0] aa, input logic wr,
                               input logic [31:0] wd, input logic rd);
    expectT e;
    bit     fl;
    bit     al;
    @(negedge CLOCK_50);
    operationMode    = mode;
    fetchAddress     = fa;
    memAccessAddress = aa;
    memAccessWren    = wr;
    memAccessData    = wd;
    memAccessRden    = rd;
    fl = legalAddr(fa, mode);
    al = legalAddr(aa, mode);
    if (!fl)                      e.fetch = 32'h0;
    else if (wr && al && aa == fa) e.fetch = wd;
    else                          e.fetch = model[int'(fa)];
    if (rd) modelMemOut = al ? model[int'(aa)] : 32'h0;
    e.mem   = modelMemOut;
    e.fault = !fl || ((wr || rd) && !al);
    if (e.fault && modelCount < 255) modelCount++;
    e.count = 8'(modelCount);
    if (wr && al) model[int'(aa)] = wd;
    sbq.push_back(e);
  endtask

  task automatic driveJunk();
    operationMode    = 1'b0;
    fetchAddress     = 16'hFFFF;
    memAccessAddress = 16'd5;
    memAccessWren    = 1'b1;
    memAccessData    = 32'hAAAA5555;
    memAccessRden    = 1'b1;
  endtask

  // Count edges from reset release until ready, with a bounded wait.
  task automatic waitReady();
    int  edges;
    bit  done;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < DEPTH + 20) begin
      @(posedge CLOCK_50);
      #1;
      edges++;
      if (edges == 50) begin
        checkOutput("initFetchZero", fetchOutput, 32'h0);
        checkOutput("initMemZero", memAccessOutput, 32'h0);
        checkOutput("initNoFault", {31'h0, accessFault}, 32'h0);
        checkOutput("initCountZero", {24'h0, faultCount}, 32'h0);
      end
      if (ready) done = 1'b1;
    end
    checkOutput("initCycles", edges, DEPTH);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Ready"}, {31'h0, ready}, 32'h0);
    checkOutput({tag, "Fetch"}, fetchOutput, 32'h0);
    checkOutput({tag, "Mem"}, memAccessOutput, 32'h0);
    checkOutput({tag, "Fault"}, {31'h0, accessFault}, 32'h0);
    checkOutput({tag, "Count"}, {24'h0, faultCount}, 32'h0);
  endtask

  task automatic randomTraffic(input int n);
    repeat (n) begin
      applyStimulus(1'($urandom_range(0, 1)), pickAddr(), pickAddr(),
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  // Monitor: each cycle with an outstanding expectation, compare the DUT outputs.
  always begin
    expectT e;
    @(posedge CLOCK_50);
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput("ready", {31'h0, ready}, 32'h1);
      checkOutput("fetchOutput", fetchOutput, e.fetch);
      checkOutput("memAccessOutput", memAccessOutput, e.mem);
      checkOutput("accessFault", {31'h0, accessFault}, {31'h0, e.fault});
      checkOutput("faultCount", {24'h0, faultCount}, {24'h0, e.count});
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    RESET_N = 1'b0;
    driveJunk();
    modelReset();
    #23;
    checkResetState("por");
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    waitReady();

    // Every word reads back zero on both ports after the clearing sweep.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'(i), 16'(i), 1'b0, 32'h0, 1'b1);

    // Kernel write then read back.
    applyStimulus(1'b1, 16'd0, 16'd5, 1'b1, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 16'd0, 16'd5, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 16'd5, 16'd0, 1'b0, 32'h0, 1'b0);

    // Write-forward to fetch, read-before-write on the access port.
    applyStimulus(1'b1, 16'd7, 16'd7, 1'b1, 32'h12345678, 1'b1);
    applyStimulus(1'b1, 16'd7, 16'd7, 1'b0, 32'h0, 1'b1);

    if (PROTECT_ON) begin
      applyStimulus(1'b0, 16'd0, KERNEL_BASE, 1'b1, 32'hCAFEF00D, 1'b0);
      applyStimulus(1'b1, 16'd0, KERNEL_BASE, 1'b0, 32'h0, 1'b1);
    end

    randomTraffic(1500);

    // Persistent illegal fetch drives the counter into saturation.
    repeat (300) applyStimulus(1'b1, 16'hFFFF, 16'd0, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset from READY clears everything immediately.
    @(posedge CLOCK_50);
    #3;
    driveJunk();
    RESET_N = 1'b0;
    #1;
    checkResetState("asyncRst");
    modelReset();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    // Interrupt the clearing sweep part-way and restart it.
    repeat (100) @(posedge CLOCK_50);
    #2;
    RESET_N = 1'b0;
    #1;
    checkResetState("midInitRst");
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    waitReady();

    // Earlier contents are gone after the restarted sweep.
    applyStimulus(1'b1, 16'd5, 16'd7, 1'b0, 32'h0, 1'b1);
    randomTraffic(200);

    @(posedge CLOCK_50);
    #3;
    checkOutput("queueDrained", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
